sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_port_arbiter_rr.sv | 32 +++
 rtl/sram_port_arbiter.sv | 104 ++++++++++
 tb/tb_sram_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants and the read-tag type used by the SRAM port arbiter.
package sram_arb_pkg;

    localparam int MAX_REQ        = 16;
    localparam int MAX_RD_LATENCY = 4;
    localparam int TAG_ID_W       = $clog2(MAX_REQ);

    // One stage of the read-return pipeline: a valid bit and the issuing requester.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/sram_port_arbiter_rr.sv
// Round-robin search: first requester at or after ptr, wrapping at N-1.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             any_grant
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    int             offset;

    // Rotating the request vector by ptr turns the wrap-around search into a priority encode.
    always_comb begin
        doubled   = {req, req} >> ptr;
        rotated   = doubled[N-1:0];
        offset    = 0;
        any_grant = |rotated;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i;
            end
        end
        winner = IDX_W'((int'(ptr) + offset) % N);
        grant  = N'(any_grant) << winner;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM among NUM_REQ requesters and tags read data back to its issuer.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            clear,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            mem_en,
    output logic                            mem_wr_en,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_din,
    input  logic [DATA_WIDTH-1:0]           mem_dout,
    output logic                            busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]   ptr_r;
    logic [NUM_REQ-1:0] req_masked;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   winner;
    logic               any_grant;
    logic               win_we;
    rd_tag_t            pipe [RD_LATENCY];

    // Requests are hidden from the arbiter during reset and clear so nothing can be granted.
    assign req_masked = (clear || !rstn) ? '0 : req_valid;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req_masked),
        .ptr       (ptr_r),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant)
    );

    assign req_ready = grant;
    assign win_we    = 1'(req_we >> winner);

    always_comb begin
        mem_en    = any_grant;
        mem_wr_en = any_grant && win_we;
        mem_addr  = '0;
        mem_din   = '0;
        if (any_grant) begin
            mem_addr = ADDR_WIDTH'(req_addr >> (int'(winner) * ADDR_WIDTH));
            mem_din  = DATA_WIDTH'(req_wdata >> (int'(winner) * DATA_WIDTH));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= '0;
        end else if (clear) begin
            ptr_r <= '0;
        end else if (any_grant) begin
            ptr_r <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
        end
    end

    // Read tags march one stage per cycle; the last stage lines up with mem_dout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= any_grant && !win_we;
            pipe[0].id    <= TAG_ID_W'(winner);
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            busy = busy | pipe[i].valid;
        end
        rsp_valid = NUM_REQ'(pipe[RD_LATENCY-1].valid) << pipe[RD_LATENCY-1].id;
        rsp_data  = pipe[RD_LATENCY-1].valid ? mem_dout : '0;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: vector table for arbitration/read-return, hand sequences for reset and NUM_REQ=1.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clear;
    logic [3:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [31:0] req_addr, req_wdata;
    logic [7:0]  rsp_data, mem_addr, mem_din, mem_dout;
    logic        mem_en, mem_wr_en, busy;

    logic        s_valid, s_ready, s_we, s_rsp_valid, s_en, s_wr, s_busy;
    logic [7:0]  s_addr, s_wdata, s_rsp_data, s_mem_addr, s_mem_din;

    logic [7:0]  sram [256];
    logic [7:0]  rd1, rd2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        clr;
        logic [3:0]  valid, we;
        logic [31:0] addr, wdata;
        logic [3:0]  e_ready;
        logic        e_en, e_wr;
        logic [7:0]  e_maddr, e_mdin;
        logic [3:0]  e_rsp;
        logic [7:0]  e_rdata;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_LATENCY(2)
    ) u_dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    sram_port_arbiter #(
        .NUM_REQ(1), .DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_LATENCY(1)
    ) u_dut1 (
        .clk(clk), .rstn(rstn), .clear(1'b0),
        .req_valid(s_valid), .req_ready(s_ready), .req_we(s_we),
        .req_addr(s_addr), .req_wdata(s_wdata),
        .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data),
        .mem_en(s_en), .mem_wr_en(s_wr), .mem_addr(s_mem_addr),
        .mem_din(s_mem_din), .mem_dout(8'h5A), .busy(s_busy)
    );

    // Two-cycle SRAM model: read data appears two cycles after the issue cycle.
    always @(posedge clk) begin
        if (mem_en && mem_wr_en) sram[mem_addr] <= mem_din;
        rd1 <= sram[mem_addr];
        rd2 <= rd1;
    end
    assign mem_dout = rd2;

    task automatic compareField(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic addVec(input logic clr, input logic [3:0] valid, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] e_ready, input logic e_en, input logic e_wr,
                          input logic [7:0] e_maddr, input logic [7:0] e_mdin,
                          input logic [3:0] e_rsp, input logic [7:0] e_rdata, input logic e_busy);
        vec_t v;
        v.clr = clr; v.valid = valid; v.we = we; v.addr = addr; v.wdata = wdata;
        v.e_ready = e_ready; v.e_en = e_en; v.e_wr = e_wr; v.e_maddr = e_maddr;
        v.e_mdin = e_mdin; v.e_rsp = e_rsp; v.e_rdata = e_rdata; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        clear     = v.clr;
        req_valid = v.valid;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        compareField("req_ready", idx, 32'(req_ready), 32'(v.e_ready));
        compareField("mem_en",    idx, 32'(mem_en),    32'(v.e_en));
        compareField("mem_wr_en", idx, 32'(mem_wr_en), 32'(v.e_wr));
        compareField("mem_addr",  idx, 32'(mem_addr),  32'(v.e_maddr));
        compareField("mem_din",   idx, 32'(mem_din),   32'(v.e_mdin));
        compareField("rsp_valid", idx, 32'(rsp_valid), 32'(v.e_rsp));
        compareField("busy",      idx, 32'(busy),      32'(v.e_busy));
        if (v.e_rsp != 4'b0000) compareField("rsp_data", idx, 32'(rsp_data), 32'(v.e_rdata));
    endtask

    localparam logic [31:0] A = 32'h2322_2120;

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 8'(i + 8'h40);
        rstn = 1'b0; clear = 1'b0;
        req_valid = 4'b1111; req_we = '0; req_addr = A; req_wdata = '0;
        s_valid = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;

        // Round-robin through all four readers, then write/read-back, wrap, back-to-back, clear.
        //     clr valid    we       addr          wdata          rdy      en wr maddr mdin rsp      rdata busy
        addVec(0, 4'b1111, 4'b0000, A,            32'h0,         4'b0001, 1, 0, 8'h20, 8'h00, 4'b0000, 8'h00, 0);
        addVec(0, 4'b1110, 4'b0000, A,            32'h0,         4'b0010, 1, 0, 8'h21, 8'h00, 4'b0000, 8'h00, 1);
        addVec(0, 4'b1100, 4'b0000, A,            32'h0,         4'b0100, 1, 0, 8'h22, 8'h00, 4'b0001, 8'h60, 1);
        addVec(0, 4'b1000, 4'b0000, A,            32'h0,         4'b1000, 1, 0, 8'h23, 8'h00, 4'b0010, 8'h61, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0100, 8'h62, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b1000, 8'h63, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0);
        addVec(0, 4'b0100, 4'b0100, 32'h0010_0000, 32'h00A5_0000, 4'b0100, 1, 1, 8'h10, 8'hA5, 4'b0000, 8'h00, 0);
        addVec(0, 4'b0001, 4'b0000, 32'h0000_0010, 32'h0,        4'b0001, 1, 0, 8'h10, 8'h00, 4'b0000, 8'h00, 0);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0001, 8'hA5, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0);
        addVec(0, 4'b0100, 4'b0000, A,            32'h0,         4'b0100, 1, 0, 8'h22, 8'h00, 4'b0000, 8'h00, 0);
        addVec(0, 4'b1001, 4'b0000, A,            32'h0,         4'b1000, 1, 0, 8'h23, 8'h00, 4'b0000, 8'h00, 1);
        addVec(0, 4'b0001, 4'b0000, A,            32'h0,         4'b0001, 1, 0, 8'h20, 8'h00, 4'b0100, 8'h62, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b1000, 8'h63, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0001, 8'h60, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0);
        addVec(0, 4'b0010, 4'b0000, 32'h0000_0000, 32'h0,        4'b0010, 1, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0);
        addVec(0, 4'b0010, 4'b0000, 32'h0000_0100, 32'h0,        4'b0010, 1, 0, 8'h01, 8'h00, 4'b0000, 8'h00, 1);
        addVec(0, 4'b0010, 4'b0000, 32'h0000_0200, 32'h0,        4'b0010, 1, 0, 8'h02, 8'h00, 4'b0010, 8'h40, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0010, 8'h41, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0010, 8'h42, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0);
        addVec(0, 4'b0010, 4'b0000, 32'h0000_0500, 32'h0,        4'b0010, 1, 0, 8'h05, 8'h00, 4'b0000, 8'h00, 0);
        addVec(1, 4'b1111, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0);
        addVec(0, 4'b1111, 4'b0000, A,            32'h0,         4'b0001, 1, 0, 8'h20, 8'h00, 4'b0000, 8'h00, 0);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0001, 8'h60, 1);
        addVec(0, 4'b0000, 4'b0000, A,            32'h0,         4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0);

        // Reset state, with requests already pending.
        #12;
        compareField("rst_ready",  -1, 32'(req_ready), 32'h0);
        compareField("rst_mem_en", -1, 32'(mem_en),    32'h0);
        compareField("rst_wr_en",  -1, 32'(mem_wr_en), 32'h0);
        compareField("rst_rsp",    -1, 32'(rsp_valid), 32'h0);
        compareField("rst_rdata",  -1, 32'(rsp_data),  32'h0);
        compareField("rst_busy",   -1, 32'(busy),      32'h0);
        compareField("rst_s_ready", -1, 32'(s_ready),  32'h0);
        @(negedge clk);
        rstn = 1'b1;
        req_valid = '0;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], i);
        end

        // Two reads in flight (pointer is 1 here), then an async reset mid-cycle.
        @(posedge clk); #1;
        req_valid = 4'b0010; req_we = '0; req_addr = A;
        @(negedge clk);
        compareField("rst_seq_grant1", 100, 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 4'b0100;
        @(negedge clk);
        compareField("rst_seq_grant2", 101, 32'(req_ready), 32'h4);
        compareField("rst_seq_busy",   101, 32'(busy),      32'h1);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        rstn = 1'b0;
        #1;
        compareField("mid_rst_ready", 102, 32'(req_ready), 32'h0);
        compareField("mid_rst_en",    102, 32'(mem_en),    32'h0);
        compareField("mid_rst_rsp",   102, 32'(rsp_valid), 32'h0);
        compareField("mid_rst_rdata", 102, 32'(rsp_data),  32'h0);
        compareField("mid_rst_busy",  102, 32'(busy),      32'h0);
        req_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            compareField("post_rst_rsp",  103 + k, 32'(rsp_valid), 32'h0);
            compareField("post_rst_busy", 103 + k, 32'(busy),      32'h0);
        end
        @(posedge clk); #1;
        req_valid = 4'b1111;
        @(negedge clk);
        compareField("post_rst_first_grant", 106, 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;

        // Single-requester pass-through with one-cycle read latency.
        s_valid = 1'b1; s_we = 1'b0; s_addr = 8'h33;
        @(negedge clk);
        compareField("n1_ready",    200, 32'(s_ready),    32'h1);
        compareField("n1_mem_en",   200, 32'(s_en),       32'h1);
        compareField("n1_mem_addr", 200, 32'(s_mem_addr), 32'h33);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        compareField("n1_ready_idle", 201, 32'(s_ready),     32'h0);
        compareField("n1_rsp_valid",  201, 32'(s_rsp_valid), 32'h1);
        compareField("n1_rsp_data",   201, 32'(s_rsp_data),  32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
